// File: rtl/plot_framebuffer.sv
// 320x240x3 plot framebuffer with 640x480@60 VGA scanout (2x pixel doubling).
// Define FB_CLEAR_EN to build the CLEAR/READY sweep that zeroes the buffer after reset or on clear_req.
module plot_framebuffer #(
    parameter int CLK_DIV = 2,
    parameter int FB_W    = 320,
    parameter int FB_H    = 240
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [8:0] plot_x,
    input  logic [7:0] plot_y,
    input  logic [2:0] plot_colour,
    input  logic       plot,
    input  logic       clear_req,
    output logic       ready,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic       vga_blank_n,
    output logic       frame_start
);
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_reg;
    logic [9:0]       hcount_reg;
    logic [9:0]       vcount_reg;
    logic             pix_tick;

    assign pix_tick = (div_reg == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_reg    <= '0;
            hcount_reg <= '0;
            vcount_reg <= '0;
        end else begin
            div_reg <= pix_tick ? '0 : div_reg + DIV_W'(1);
            if (pix_tick) begin
                if (hcount_reg == 10'd799) begin
                    hcount_reg <= '0;
                    vcount_reg <= (vcount_reg == 10'd524) ? 10'd0 : vcount_reg + 10'd1;
                end else begin
                    hcount_reg <= hcount_reg + 10'd1;
                end
            end
        end
    end

    logic        active;
    logic        hsync_now;
    logic        vsync_now;
    logic [16:0] rd_addr;

    assign active    = (hcount_reg < 10'd640) && (vcount_reg < 10'd480);
    assign hsync_now = !((hcount_reg >= 10'd656) && (hcount_reg <= 10'd751));
    assign vsync_now = !((vcount_reg >= 10'd490) && (vcount_reg <= 10'd491));

    always_comb begin
        rd_addr = '0;
        if (active) begin
            rd_addr = 17'(vcount_reg[9:1]) * 17'(FB_W) + 17'(hcount_reg[9:1]);
        end
    end

    logic        plot_ok;
    logic [16:0] plot_addr;
    logic        wr_en;
    logic [16:0] wr_addr;
    logic [2:0]  wr_data;

    assign plot_ok   = plot && ready && (32'(plot_x) < FB_W) && (32'(plot_y) < FB_H);
    assign plot_addr = 17'(plot_y) * 17'(FB_W) + 17'(plot_x);

`ifdef FB_CLEAR_EN
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]  state_reg;
    logic [16:0] clr_addr_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= ST_CLEAR;
            clr_addr_reg <= '0;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    if (clr_addr_reg == 17'(FB_DEPTH - 1)) begin
                        state_reg    <= ST_READY;
                        clr_addr_reg <= '0;
                    end else begin
                        clr_addr_reg <= clr_addr_reg + 17'd1;
                    end
                end
                default: begin
                    // The plot presented alongside clear_req still lands; the sweep then overwrites it.
                    if (clear_req) begin
                        state_reg    <= ST_CLEAR;
                        clr_addr_reg <= '0;
                    end
                end
            endcase
        end
    end

    assign ready = (state_reg == ST_READY);

    always_comb begin
        wr_en   = plot_ok;
        wr_addr = plot_addr;
        wr_data = plot_colour;
        if (state_reg == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr_reg;
            wr_data = 3'b000;
        end
    end
`else
    logic unused_clear_req;

    assign unused_clear_req = clear_req;
    assign ready   = 1'b1;
    assign wr_en   = plot_ok;
    assign wr_addr = plot_addr;
    assign wr_data = plot_colour;
`endif

    logic [2:0] fb_mem [FB_DEPTH];
    logic [2:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            fb_mem[wr_addr] <= wr_data;
        end
        rd_data_reg <= fb_mem[rd_addr];
    end

    // Stage 1 carries timing alongside the RAM read; stage 2 drives the pins.
    logic       s1_active_reg;
    logic       s1_hsync_reg;
    logic       s1_vsync_reg;
    logic       s1_origin_reg;
    logic [2:0] colour_reg;
    logic       hsync_reg;
    logic       vsync_reg;
    logic       blank_n_reg;
    logic       frame_start_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_active_reg   <= 1'b0;
            s1_hsync_reg    <= 1'b1;
            s1_vsync_reg    <= 1'b1;
            s1_origin_reg   <= 1'b0;
            colour_reg      <= '0;
            hsync_reg       <= 1'b1;
            vsync_reg       <= 1'b1;
            blank_n_reg     <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            s1_active_reg   <= active;
            s1_hsync_reg    <= hsync_now;
            s1_vsync_reg    <= vsync_now;
            s1_origin_reg   <= active && (hcount_reg == 10'd0) && (vcount_reg == 10'd0);
            colour_reg      <= s1_active_reg ? rd_data_reg : 3'b000;
            hsync_reg       <= s1_hsync_reg;
            vsync_reg       <= s1_vsync_reg;
            blank_n_reg     <= s1_active_reg;
            // (0,0) is held for CLK_DIV clocks; only the blank->active edge marks the frame.
            frame_start_reg <= s1_origin_reg && !blank_n_reg;
        end
    end

    assign vga_r       = {8{colour_reg[2]}};
    assign vga_g       = {8{colour_reg[1]}};
    assign vga_b       = {8{colour_reg[0]}};
    assign vga_hsync   = hsync_reg;
    assign vga_vsync   = vsync_reg;
    assign vga_blank_n = blank_n_reg;
    assign frame_start = frame_start_reg;
endmodule

// File: tb/tb_plot_framebuffer.sv
// Randomised plot/scanout bench for plot_framebuffer against a pixel-position and framebuffer model.
module tb_plot_framebuffer;
    localparam int CLK_DIV = 2;
    localparam int FB_W    = 320;
    localparam int FB_H    = 240;
    localparam int DEPTH   = FB_W * FB_H;
`ifdef FB_CLEAR_EN
    localparam int PHASE1  = 78000;
    localparam int PHASE2  = 2000;
`else
    localparam int PHASE1  = 26000;
    localparam int PHASE2  = 12000;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [8:0] plot_x = '0;
    logic [7:0] plot_y = '0;
    logic [2:0] plot_colour = '0;
    logic       plot = 1'b0;
    logic       clear_req = 1'b0;
    logic       ready;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hsync, vga_vsync, vga_blank_n, frame_start;

    always #5 clk = ~clk;

    plot_framebuffer #(.CLK_DIV(CLK_DIV), .FB_W(FB_W), .FB_H(FB_H)) dut (
        .clk(clk), .rstn(rstn),
        .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
        .plot(plot), .clear_req(clear_req), .ready(ready),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .vga_blank_n(vga_blank_n), .frame_start(frame_start)
    );

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    typedef struct { int at; int addr; logic [2:0] col; } wr_t;
    wr_t        pend[$];
    logic [2:0] fb_col   [DEPTH];
    bit         fb_known [DEPTH];
    bit         clr_on   = 1'b0;
    int         clr_base = 1;
    int         clr_ptr  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // ready as seen after edge e; a sweep owns the write port from edge clr_base-1 for DEPTH clocks
    function automatic bit ready_model(input int e);
        return !(clr_on && e >= clr_base - 1 && e < clr_base + DEPTH - 1);
    endfunction

    // memory contents visible to a read issued at edge e-1: all writes made at edges <= e-2
    task automatic apply_model(input int e);
        while (pend.size() > 0 && pend[0].at <= e - 2) begin
            fb_col[pend[0].addr]   = pend[0].col;
            fb_known[pend[0].addr] = 1'b1;
            void'(pend.pop_front());
        end
        while (clr_on && clr_ptr < DEPTH && clr_base + clr_ptr <= e - 2) begin
            fb_col[clr_ptr]   = 3'b000;
            fb_known[clr_ptr] = 1'b1;
            clr_ptr++;
        end
    endtask

    function automatic int scan_row(input int e);
        int v;
        if (e < 2) return 0;
        v = ((e - 2) / CLK_DIV / 800) % 525;
        return (v < 480) ? v / 2 : 0;
    endfunction

    function automatic int scan_h(input int e);
        if (e < 2) return 0;
        return ((e - 2) / CLK_DIV) % 800;
    endfunction

    task automatic check_cycle();
        int k, t, h, v, a;
        bit act, hs, vs, fs;
        logic [2:0] c;
        apply_model(edge_n);
        act = 0; hs = 1; vs = 1; fs = 0;
        c = 3'b000;
        a = 0;
        if (edge_n >= 2) begin
            k = edge_n - 2;
            t = k / CLK_DIV;
            h = t % 800;
            v = (t / 800) % 525;
            act = (h < 640) && (v < 480);
            hs  = !(h >= 656 && h <= 751);
            vs  = !(v >= 490 && v <= 491);
            fs  = act && h == 0 && v == 0 && (k % CLK_DIV == 0);
            if (act) begin
                a = (v / 2) * FB_W + h / 2;
                c = fb_col[a];
            end
        end
        check("sync", {vga_blank_n, vga_hsync, vga_vsync, frame_start}, {act, hs, vs, fs});
        if (!act)
            check("blank_rgb", {vga_r, vga_g, vga_b}, 32'h0);
        else if (fb_known[a])
            check("pixel_rgb", {vga_r, vga_g, vga_b}, {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}});
        check("ready", ready, ready_model(edge_n));
    endtask

    task automatic drive_set(input bit p, input int x, input int y, input logic [2:0] col, input bit cr);
        plot        = p;
        plot_x      = 9'(x);
        plot_y      = 8'(y);
        plot_colour = col;
        clear_req   = cr;
        if (p && ready_model(edge_n) && x < FB_W && y < FB_H)
            pend.push_back('{at: edge_n + 1, addr: y * FB_W + x, col: col});
`ifdef FB_CLEAR_EN
        if (cr && ready_model(edge_n)) begin
            clr_on   = 1'b1;
            clr_base = edge_n + 2;
            clr_ptr  = 0;
        end
`endif
    endtask

    task automatic drive_random();
        int x, y, r;
        bit cr;
        r = int'($urandom_range(0, 15));
        x = (r == 0) ? int'($urandom_range(FB_W, 511)) : int'($urandom_range(0, FB_W - 1));
        if (r == 1)      y = int'($urandom_range(FB_H, 255));
        else if (r < 6)  y = int'($urandom_range(0, FB_H - 1));
        else             y = scan_row(edge_n) + int'($urandom_range(0, 6));
        if (y > 255) y = FB_H - 1;
`ifdef FB_CLEAR_EN
        cr = 1'b0;
`else
        cr = bit'($urandom_range(0, 1));
`endif
        drive_set(bit'($urandom_range(0, 1)), x, y, 3'($urandom), cr);
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        check_cycle();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            fb_known[i] = 1'b0;
            fb_col[i]   = 3'b000;
        end
`ifdef FB_CLEAR_EN
        clr_on = 1'b1; clr_base = 1; clr_ptr = 0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        edge_n = 0;
        check_cycle();
        rstn = 1'b1;

        drive_set(1'b1, 5, 3, 3'b101, 1'b0);
        step();
        drive_set(1'b1, 320, 0, 3'b111, 1'b0);
        step();
        drive_set(1'b1, 0, 240, 3'b111, 1'b0);
        step();
        for (int i = 0; i < PHASE1; i++) begin
            drive_random();
            step();
        end

        // clear request together with a plot to (0,0)
        drive_set(1'b1, 0, 0, 3'b111, 1'b1);
        step();
        for (int i = 0; i < 300; i++) begin
            drive_random();
            step();
        end

        // run to roughly hcount 300 of an active line, then pull reset between edges
        for (int i = 0; i < 2000; i++) begin
            if (scan_h(edge_n) >= 295 && scan_h(edge_n) <= 305 &&
                ((edge_n - 2) / CLK_DIV / 800) % 525 < 480) break;
            drive_random();
            step();
        end
        drive_set(1'b0, 0, 0, 3'b000, 1'b0);
        #1 rstn = 1'b0;
        #1;
        check("async_reset", {vga_r, vga_g, vga_b, vga_blank_n, vga_hsync, vga_vsync, frame_start},
              {24'h0, 1'b0, 1'b1, 1'b1, 1'b0});
        apply_model(edge_n + 2);
        pend.delete();
`ifdef FB_CLEAR_EN
        clr_on = 1'b1; clr_base = 1; clr_ptr = 0;
        check("reset_ready", ready, 1'b0);
`else
        check("reset_ready", ready, 1'b1);
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        edge_n = 0;
        check_cycle();
        rstn = 1'b1;
        for (int i = 0; i < PHASE2; i++) begin
            drive_random();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/plot_framebuffer.md
# plot_framebuffer

Receiving end of the pixel-plot interface driven by the fractal generator: accepts (x, y, colour, plot) writes into a 320×240×3-bit on-chip framebuffer and continuously scans it out as 640×480@60 VGA, with 2× pixel doubling. Sits between the generator and the board DAC/VGA pins. An optional power-up/on-demand clear sweep zeroes the framebuffer before writes are accepted.

## Interface
Parameters:
- CLK_DIV, 2, system clocks per VGA pixel (2 for 50 MHz clk → 25 MHz pixel rate)
- FB_W, 320, framebuffer width in pixels
- FB_H, 240, framebuffer height in pixels

Ports:
- clk  input  1  system clock; all logic on rising edge
- rstn  input  1  asynchronous, active-low reset
- plot_x  input  9  write column, 0..FB_W-1
- plot_y  input  8  write row, 0..FB_H-1
- plot_colour  input  3  write colour {R,G,B}
- plot  input  1  write strobe, one write per cycle while high
- clear_req  input  1  request full clear (ignored without macro)
- ready  output  1  writes accepted this cycle
- vga_r, vga_g, vga_b  output  8 each  colour bit replicated ×8 during active, 0 in blanking
- vga_hsync, vga_vsync  output  1 each  active-low syncs
- vga_blank_n  output  1  high in active video
- frame_start  output  1  one-clk pulse with first active pixel (0,0) of each frame

## Operation
- Pixel tick: divider counts 0..CLK_DIV-1; tick when divider = CLK_DIV-1.
- On tick: hcount 0..799 increments, wraps to 0 and increments vcount 0..524, which wraps to 0.
- Active: hcount<640 and vcount<480. hsync low for hcount 656..751; vsync low for vcount 490..491.
- Read address = (vcount>>1)*FB_W + (hcount>>1), 17 bits; computed only for active positions.
- Write: when plot & ready & plot_x<FB_W & plot_y<FB_H, store plot_colour at plot_y*FB_W+plot_x. Out-of-range or not-ready writes are silently dropped; no backpressure beyond ready.
- Framebuffer is a simple dual-port RAM: one write port (plot/clear), one read port (scanout), 1-cycle registered read. Simultaneous read/write of the same address returns old data; new data visible from the next cycle.
- State machine (macro enabled): CLEAR → READY. CLEAR writes 0 to addresses 0..FB_W*FB_H-1, one per clk, ready=0. After address 76799 is written, READY next cycle (ready=1). In READY, clear_req=1 → CLEAR from address 0 next cycle; plot in that same cycle is still accepted. clear_req during CLEAR ignored. Scanout runs unaffected in both states.

## Timing
- Reset values: divider, hcount, vcount = 0; vga_r/g/b = 0; vga_hsync = vga_vsync = 1; vga_blank_n = 0; frame_start = 0; ready = 0 with macro (state CLEAR, address 0), 1 without.
- Output pipeline: colour, syncs and blank_n for counter position (h,v) appear 2 clk after the counters take that value, all mutually aligned (syncs/blank delayed to match RAM read).
- frame_start pulses exactly once per frame, 1 clk wide, in the same cycle vga_blank_n first rises for (0,0).
- Write latency: a write accepted in cycle t affects scanout of that pixel at the earliest on a read issued at t+1.
- Reset asserted mid-frame or mid-clear: all state returns to reset values immediately; clear restarts from address 0 on release.
- Frame period: 800×525×CLK_DIV clks (840000 at CLK_DIV=2).

## Configuration
- FB_CLEAR_EN defined: CLEAR/READY state machine built; ready=0 for 76800 clks after reset and after each accepted clear_req; framebuffer guaranteed all-zero before first accepted write.
- FB_CLEAR_EN undefined: no clear logic; ready tied to 1; clear_req unused; framebuffer contents undefined after reset until written.

## Test plan
- Reset release, CLK_DIV=2: first vga_hsync fall at 2×656+2 clk, low for 192 clk; vsync low for lines 490–491; frame_start every 840000 clk.
- FB_CLEAR_EN: reset release → ready=0 for exactly 76800 clk, then 1; all scanned pixels of following frame have vga_r/g/b = 0.
- Plot (x=5,y=3,colour=3'b101) → screen pixels hcount 10–11, vcount 6–7 show vga_r=8'hFF, vga_g=0, vga_b=8'hFF; neighbours unchanged.
- Plot x=320,y=0 and x=0,y=240 → no framebuffer change; ready stays 1.
- FB_CLEAR_EN: clear_req in READY with simultaneous plot (0,0,3'b111) → plot written then cleared; ready low 76800 clk; plots during CLEAR dropped.
- rstn pulsed low mid-line (hcount≈300) → outputs return to reset values asynchronously; counters restart at (0,0) on release.
